// File: rtl/hwpe_tcdm_mux_if.sv
// ----------------------------------------------------------------------------
// hwpe_tcdm_mux_if
//
// Bundles the N_SLAVE_PORT HWPE-side TCDM ports and the single TCDM master port
// of hwpe_tcdm_mux. Signal directions in the names are as seen by the mux.
//
// Modports:
//   slave  - the mux itself (accepts HWPE requests, drives the interconnect)
//   master - the environment (HWPE data mover + interconnect/memory side)
//
// Signals:
//   s_req_i/s_gnt_o                 per-port request / grant
//   s_add_i/s_wen_i/s_be_i/s_wdata_i per-port request payload (wen: 1 = read)
//   s_r_rdata_o/s_r_valid_o          per-port response (rdata broadcast)
//   m_req_o/m_gnt_i                  master request / grant
//   m_add_o/m_wen_o/m_be_o/m_wdata_o master request payload
//   m_r_rdata_i/m_r_valid_i          master response
// ----------------------------------------------------------------------------
interface hwpe_tcdm_mux_if #(
    parameter int unsigned N_SLAVE_PORT = 4
);
    logic [N_SLAVE_PORT-1:0]        s_req_i;
    logic [N_SLAVE_PORT-1:0]        s_gnt_o;
    logic [N_SLAVE_PORT-1:0][31:0]  s_add_i;
    logic [N_SLAVE_PORT-1:0]        s_wen_i;
    logic [N_SLAVE_PORT-1:0][3:0]   s_be_i;
    logic [N_SLAVE_PORT-1:0][31:0]  s_wdata_i;
    logic [N_SLAVE_PORT-1:0][31:0]  s_r_rdata_o;
    logic [N_SLAVE_PORT-1:0]        s_r_valid_o;

    logic                           m_req_o;
    logic                           m_gnt_i;
    logic [31:0]                    m_add_o;
    logic                           m_wen_o;
    logic [3:0]                     m_be_o;
    logic [31:0]                    m_wdata_o;
    logic [31:0]                    m_r_rdata_i;
    logic                           m_r_valid_i;

    modport slave (
        input  s_req_i, s_add_i, s_wen_i, s_be_i, s_wdata_i,
        output s_gnt_o, s_r_rdata_o, s_r_valid_o,
        output m_req_o, m_add_o, m_wen_o, m_be_o, m_wdata_o,
        input  m_gnt_i, m_r_rdata_i, m_r_valid_i
    );

    modport master (
        output s_req_i, s_add_i, s_wen_i, s_be_i, s_wdata_i,
        input  s_gnt_o, s_r_rdata_o, s_r_valid_o,
        input  m_req_o, m_add_o, m_wen_o, m_be_o, m_wdata_o,
        output m_gnt_i, m_r_rdata_i, m_r_valid_i
    );
endinterface

// File: rtl/hwpe_tcdm_mux.sv
// ----------------------------------------------------------------------------
// hwpe_tcdm_mux
//
// Merges N_SLAVE_PORT TCDM-style ports from the HWPE data mover onto a single
// TCDM master port toward the L2 interconnect. Round-robin arbitration with
// request locking; an in-order ID FIFO routes each response back to the port
// that issued the matching request.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   bus          hwpe_tcdm_mux_if.slave (HWPE ports + master port)
//   err_o        sticky: response received while no request was outstanding
//   stall_cnt_o  arbitration stall counter (zero unless enabled)
//
// Optional feature macro: HWPE_TCDM_MUX_STALL_CNT_EN
//   defined   - stall_cnt_o counts cycles with any request and no handshake,
//               saturating at all-ones
//   undefined - stall_cnt_o tied to zero, no counter flops
// ----------------------------------------------------------------------------
module hwpe_tcdm_mux #(
    parameter int unsigned N_SLAVE_PORT    = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    hwpe_tcdm_mux_if.slave         bus,
    output logic                   err_o,
    output logic [31:0]            stall_cnt_o
);

    localparam int unsigned IdxW = (N_SLAVE_PORT > 1) ? $clog2(N_SLAVE_PORT) : 1;
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = PtrW + 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [IdxW-1:0] r_rr_ptr;
    logic [IdxW-1:0] r_lock_idx;
    logic            r_locked;
    logic [IdxW-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            r_err;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic            w_full;
    logic            w_empty;
    logic            w_lock_act;
    logic            w_win_found;
    logic [IdxW-1:0] w_win_idx;
    logic [IdxW-1:0] w_cand;
    logic            w_hs;
    logic            w_push;
    logic            w_pop;
    logic [IdxW-1:0] w_head;
    logic [N_SLAVE_PORT-1:0] w_gnt;
    logic [N_SLAVE_PORT-1:0] w_rvalid;

    // Fullness comes from the registered count only: a pop this cycle does
    // not open a slot for a grant until the next cycle.
    assign w_full  = (r_count == CntW'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);

    // A lock whose owner has dropped its request no longer constrains the
    // winner; the lock register itself is cleared at the next edge.
    assign w_lock_act = r_locked & bus.s_req_i[r_lock_idx];

    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        if (!w_full) begin
            if (w_lock_act) begin
                w_win_found = 1'b1;
                w_win_idx   = r_lock_idx;
            end else begin
                // First requester at or after the round-robin pointer, wrapping.
                for (int unsigned k = 0; k < N_SLAVE_PORT; k++) begin
                    w_cand = IdxW'((32'(r_rr_ptr) + k) % N_SLAVE_PORT);
                    if (!w_win_found && bus.s_req_i[w_cand]) begin
                        w_win_found = 1'b1;
                        w_win_idx   = w_cand;
                    end
                end
            end
        end
    end

    assign w_hs   = w_win_found & bus.m_gnt_i;
    assign w_push = w_hs;

    always_comb begin
        w_gnt = '0;
        if (w_win_found) begin
            w_gnt[w_win_idx] = bus.m_gnt_i;
        end
    end

    assign bus.s_gnt_o   = w_gnt;
    assign bus.m_req_o   = w_win_found;
    assign bus.m_add_o   = bus.s_add_i[w_win_idx];
    assign bus.m_wen_o   = bus.s_wen_i[w_win_idx];
    assign bus.m_be_o    = bus.s_be_i[w_win_idx];
    assign bus.m_wdata_o = bus.s_wdata_i[w_win_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            r_locked   <= 1'b0;
        end else begin
            if (w_hs) begin
                r_rr_ptr <= IdxW'((32'(w_win_idx) + 32'd1) % N_SLAVE_PORT);
            end
            if (w_win_found && !bus.m_gnt_i) begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_win_idx;
            end else if (w_hs || !w_lock_act) begin
                r_locked <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response routing FIFO
    // ------------------------------------------------------------------------
    assign w_head = r_fifo[r_rd_ptr];
    assign w_pop  = bus.m_r_valid_i & ~w_empty;

    always_comb begin
        w_rvalid = '0;
        if (w_pop) begin
            w_rvalid[w_head] = 1'b1;
        end
    end

    assign bus.s_r_valid_o = w_rvalid;
    assign bus.s_r_rdata_o = {N_SLAVE_PORT{bus.m_r_rdata_i}};

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_win_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    // A response with nothing outstanding means the mux lost track of an
    // in-flight request (e.g. reset mid-transfer); flag it until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (bus.m_r_valid_i && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

    // ------------------------------------------------------------------------
    // Stall counter
    // ------------------------------------------------------------------------
`ifdef HWPE_TCDM_MUX_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if ((|bus.s_req_i) && !w_hs && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_tcdm_mux.sv
module tb_hwpe_tcdm_mux;

    localparam int unsigned N    = 4;
    localparam int unsigned MAXO = 4;
    localparam int unsigned IW   = $clog2(N);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        err;
    logic [31:0] stall;

    hwpe_tcdm_mux_if #(.N_SLAVE_PORT(N)) bus ();

    hwpe_tcdm_mux #(
        .N_SLAVE_PORT   (N),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .err_o      (err),
        .stall_cnt_o(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          m_req;
        logic [N-1:0]  gnt;
        logic [31:0]   add;
        logic          wen;
        logic [3:0]    be;
        logic [31:0]   wdata;
        logic [N-1:0]  rvalid;
        logic [31:0]   rdata;
        logic          err;
        logic [31:0]   stall;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: outstanding port IDs in issue order, fairness pointer,
    // the port currently holding a refused request, sticky error, stall count.
    int          m_rr;
    int          m_held;
    int          m_oq[$];
    bit          m_err;
    logic [31:0] m_stall;

    int          pin_port = -1;
    logic [31:0] pin_addr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    function automatic bit bitof(input logic [N-1:0] v, input int unsigned i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    // One clock cycle of stimulus; called at posedge+1.
    task automatic cycle(input logic [N-1:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rdata);
        exp_t e;
        int   win;
        int   sz;
        bit   hs;
        bus.s_req_i     = req;
        bus.m_gnt_i     = gnt;
        bus.m_r_valid_i = rv;
        bus.m_r_rdata_i = rdata;
        for (int i = 0; i < N; i++) begin
            bus.s_add_i[IW'(i)]   = $urandom;
            bus.s_wen_i[IW'(i)]   = 1'($urandom);
            bus.s_be_i[IW'(i)]    = 4'($urandom);
            bus.s_wdata_i[IW'(i)] = $urandom;
        end
        if (pin_port >= 0) bus.s_add_i[IW'(pin_port)] = pin_addr;

        if (!rst_n) begin
            m_rr = 0; m_held = -1; m_oq.delete(); m_err = 0; m_stall = '0;
        end
        e = '{default: '0};
        sz = m_oq.size();
        if (m_held >= 0 && !bitof(req, m_held)) m_held = -1;
        win = -1;
        if (sz < MAXO) begin
            if (m_held >= 0) win = m_held;
            else for (int k = 0; k < N; k++)
                if (win < 0 && bitof(req, (m_rr + k) % N)) win = (m_rr + k) % N;
        end
        hs = (win >= 0) && gnt;
        e.m_req = (win >= 0);
        if (win >= 0) begin
            e.gnt   = gnt ? (N'(1) << win) : '0;
            e.add   = bus.s_add_i[IW'(win)];
            e.wen   = bus.s_wen_i[IW'(win)];
            e.be    = bus.s_be_i[IW'(win)];
            e.wdata = bus.s_wdata_i[IW'(win)];
        end
        if (rv && sz > 0) e.rvalid = N'(1) << m_oq[0];
        e.rdata = rdata;
        e.err   = m_err;
        e.stall = m_stall;
        exp_q.push_back(e);

        if (rst_n) begin
            if (rv) begin
                if (sz > 0) void'(m_oq.pop_front());
                else m_err = 1;
            end
            if (hs) begin
                m_oq.push_back(win);
                m_rr   = (win + 1) % N;
                m_held = -1;
            end else if (win >= 0) begin
                m_held = win;
            end
`ifdef HWPE_TCDM_MUX_STALL_CNT_EN
            if (req != '0 && !hs && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) cycle('0, 1'b0, 1'b0, $urandom);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int guard = 0;
        while (m_oq.size() > 0 && guard < 50) begin
            cycle('0, 1'b0, 1'b1, $urandom);
            guard++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares DUT outputs.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            chk("m_req", 32'(bus.m_req_o), 32'(e.m_req));
            chk("s_gnt", 32'(bus.s_gnt_o), 32'(e.gnt));
            chk("s_r_valid", 32'(bus.s_r_valid_o), 32'(e.rvalid));
            chk("err", 32'(err), 32'(e.err));
            chk("stall_cnt", stall, e.stall);
            if (e.rvalid != '0) begin
                for (int i = 0; i < N; i++) chk("s_r_rdata", bus.s_r_rdata_o[IW'(i)], e.rdata);
            end
            if (e.m_req) begin
                chk("m_add", bus.m_add_o, e.add);
                chk("m_wen", 32'(bus.m_wen_o), 32'(e.wen));
                chk("m_be", 32'(bus.m_be_o), 32'(e.be));
                chk("m_wdata", bus.m_wdata_o, e.wdata);
            end
        end
    end

    initial begin
        int guard;
        rst_n           = 1'b0;
        bus.s_req_i     = '0;
        bus.s_add_i     = '0;
        bus.s_wen_i     = '0;
        bus.s_be_i      = '0;
        bus.s_wdata_i   = '0;
        bus.m_gnt_i     = 1'b0;
        bus.m_r_valid_i = 1'b0;
        bus.m_r_rdata_i = '0;
        @(posedge clk);
        #1;
        do_reset(2);
        repeat (2) cycle('0, 1'b0, 1'b0, $urandom);

        // Single-port read from port 2, response two cycles later.
        pin_port = 2;
        pin_addr = 32'h1C01_0000;
        cycle(4'b0100, 1'b1, 1'b0, $urandom);
        cycle('0, 1'b0, 1'b0, $urandom);
        cycle('0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        pin_port = -1;

        // Lock: port 1 refused three cycles, port 0 joins in cycle 2.
        pin_port = 1;
        pin_addr = 32'h1C01_0040;
        cycle(4'b0010, 1'b0, 1'b0, $urandom);
        cycle(4'b0011, 1'b0, 1'b0, $urandom);
        cycle(4'b0011, 1'b0, 1'b0, $urandom);
        cycle(4'b0011, 1'b1, 1'b0, $urandom);
        pin_port = -1;
        cycle(4'b0001, 1'b1, 1'b1, $urandom);
        drain();

        // Round-robin with all ports requesting.
        repeat (12) cycle(4'b1111, 1'b1, m_oq.size() > 0, $urandom);
        drain();

        // FIFO full, then one response reopens granting a cycle later.
        repeat (6) cycle(4'b1111, 1'b1, 1'b0, $urandom);
        cycle(4'b1111, 1'b1, 1'b1, $urandom);
        repeat (2) cycle(4'b1111, 1'b1, 1'b0, $urandom);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [N-1:0] rq;
            rq = N'($urandom) & N'($urandom | $urandom);
            cycle(rq, $urandom_range(0, 3) != 0,
                  (m_oq.size() > 0) && ($urandom_range(0, 2) != 0), $urandom);
        end
        drain();

        // Stall counting: ten refused cycles then one grant.
        repeat (10) cycle(4'b0001, 1'b0, 1'b0, $urandom);
        cycle(4'b0001, 1'b1, 1'b0, $urandom);
        drain();
        cycle('0, 1'b0, 1'b0, $urandom);

        // Spurious response sets the sticky error.
        cycle('0, 1'b0, 1'b1, $urandom);
        repeat (3) cycle('0, 1'b0, 1'b0, $urandom);

        // Reset mid-operation flushes outstanding IDs; late responses flag error.
        repeat (3) cycle(4'b1011, 1'b1, 1'b0, $urandom);
        do_reset(2);
        repeat (3) cycle('0, 1'b0, 1'b1, $urandom);
        cycle('0, 1'b0, 1'b0, $urandom);
        do_reset(1);
        repeat (3) cycle('0, 1'b0, 1'b0, $urandom);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hwpe_tcdm_mux.md
# hwpe_tcdm_mux

Downstream stage of the FC HWPE subsystem. It merges the N_SLAVE_PORT TCDM-style master ports driven by the HWPE data mover onto a single TCDM master port toward the FC L2 interconnect. Arbitration is round-robin with request locking. An in-order ID FIFO routes each response back to the port that issued the request. It lets the accelerator share one interconnect port instead of consuming N_SLAVE_PORT ports.

## Interface
- N_SLAVE_PORT, 4, number of HWPE-side ports (2..8)
- MAX_OUTSTANDING, 4, depth of the response-routing FIFO; power of two, ≥2
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- s_req_i  in  N_SLAVE_PORT  per-port request
- s_gnt_o  out  N_SLAVE_PORT  per-port grant
- s_add_i  in  N_SLAVE_PORT×32  per-port byte address
- s_wen_i  in  N_SLAVE_PORT  per-port write-enable, active low (1 = read)
- s_be_i  in  N_SLAVE_PORT×4  per-port byte enables
- s_wdata_i  in  N_SLAVE_PORT×32  per-port write data
- s_r_rdata_o  out  N_SLAVE_PORT×32  per-port read data; m_r_rdata_i is broadcast to every port
- s_r_valid_o  out  N_SLAVE_PORT  per-port response valid (one-hot or zero)
- m_req_o, m_gnt_i, m_add_o[31:0], m_wen_o, m_be_o[3:0], m_wdata_o[31:0]  master request channel
- m_r_rdata_i[31:0], m_r_valid_i  master response channel
- err_o  out  1  sticky flag: response received with empty FIFO
- stall_cnt_o  out  32  arbitration stall counter (see Configuration)

## Operation
- Eligibility: slave i is eligible when s_req_i[i]=1 and the FIFO is not full. "Full" uses the registered count, so a pop in the same cycle does not unblock a grant.
- Winner: the first eligible port at or after rr_ptr, searching in increasing index with wrap.
- m_req_o = 1 when any port is eligible. The winner's add/wen/be/wdata are muxed combinationally onto the m_* outputs.
- s_gnt_o[winner] = m_gnt_i. All other s_gnt_o bits = 0.
- Handshake = m_req_o & m_gnt_i. On a handshake:
  - push the winner index into the FIFO;
  - set rr_ptr = (winner+1) mod N_SLAVE_PORT.
- Lock: when m_req_o=1 and m_gnt_i=0, register the winner in lock_idx and set locked=1.
  - While locked, the winner is lock_idx regardless of rr_ptr, even if other ports request.
  - locked clears on the handshake, or if s_req_i[lock_idx] drops.
- Response: when m_r_valid_i=1 and the FIFO is non-empty:
  - s_r_valid_o[head] = 1;
  - pop the head.
- Response with empty FIFO: all s_r_valid_o = 0, set err_o. err_o clears only on reset.
- Reads and writes both expect exactly one m_r_valid_i per handshake, in order.
- FIFO full: m_req_o = 0, no grants, lock state held. Granting resumes the cycle after the count drops below MAX_OUTSTANDING.
- Reset mid-operation: FIFO and lock are flushed. In-flight responses arriving after reset raise err_o.

## Timing
- Request path is combinational, zero latency: s_req_i → m_req_o, and m_gnt_i → s_gnt_o.
- Response routing is combinational from m_r_valid_i and the FIFO head, zero latency.
- m_r_valid_i is never in the same cycle as the corresponding handshake; there is a minimum 1-cycle gap.
- A push and a pop in the same cycle are both performed, and the count is unchanged.
- Registered state: rr_ptr, lock_idx, locked, FIFO pointers/count, err_o, stall counter.
- Reset values:
  - rr_ptr = 0, locked = 0, count = 0, err_o = 0, stall_cnt_o = 0;
  - all s_gnt_o, s_r_valid_o and m_req_o = 0 while no requests are present.

## Configuration
- HWPE_TCDM_MUX_STALL_CNT_EN defined:
  - stall_cnt_o increments each cycle where |s_req_i=1 and no handshake occurs, counting both grant stalls and FIFO-full stalls;
  - the counter saturates at 0xFFFF_FFFF and resets to 0.
- Not defined: stall_cnt_o is tied to 0 and no counter flops exist.

## Test plan
- Single-port read: port 2 reads 0x1C01_0000 with m_gnt_i=1 and m_r_valid_i two cycles later carrying 0xDEAD_BEEF → s_gnt_o=4'b0100 in the request cycle; s_r_valid_o=4'b0100 with s_r_rdata=0xDEAD_BEEF; err_o=0.
- Round-robin fairness: all 4 ports request continuously, m_gnt_i=1 → grant order 0,1,2,3,0,1,… with exactly one grant per cycle.
- Lock: port 1 requests, m_gnt_i=0 for 3 cycles, port 0 raises its request in cycle 2 → m_add_o stays at port 1's address until the grant; port 1 is granted first, then port 0.
- FIFO full: MAX_OUTSTANDING=4, 4 grants with no responses → m_req_o=0 in cycle 5; one m_r_valid_i → granting resumes the following cycle; responses route to ports in issue order.
- Spurious response: m_r_valid_i=1 with FIFO empty → s_r_valid_o=0 and err_o=1, held until rst_ni is asserted.
- Stall counter (macro defined): port 0 requests with m_gnt_i=0 for 10 cycles, then 1 grant → stall_cnt_o=10. Without the macro, stall_cnt_o=0.
